// File: rtl/wb_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_types_pkg: shared types for the Wishbone slave responder       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package wb_types_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_DATA = 2'd1,
    REG_STAT = 2'd2,
    REG_WAIT = 2'd3
  } wb_resp_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAITST = 2'd1,
    ST_ACK    = 2'd2
  } wb_resp_state_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_UNF_BIT   = 2;
  localparam int STAT_OVF_BIT   = 3;

endpackage
`default_nettype wire

// File: rtl/wb_resp_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_resp_fifo: synchronous byte FIFO with fall-through read data   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wb_resp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import wb_types_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_slave_responder: WB B4 classic slave, wait states + loopback   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wb_slave_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WAIT   = 15,
  parameter int RESET_WAIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       irq_o
);
  import wb_types_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_resp_state_e   state;
  logic [1:0]       ctrl;
  logic             ovf;
  logic             unf;
  logic [3:0]       wait_cfg;
  logic [3:0]       cnt;

  logic             req;
  logic             go_ack;
  logic             en;
  logic             irq_en;
  logic             data_acc;
  wb_resp_reg_e     reg_sel;
  logic [7:0]       rdata;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign req      = cyc_i & stb_i;
  assign reg_sel  = wb_resp_reg_e'(adr_i);
  assign en       = ctrl[CTRL_EN_BIT];
  assign irq_en   = ctrl[CTRL_IRQ_EN_BIT];
  // Side effects fire on the edge that enters ACK, using the bus values seen there.
  assign go_ack   = req && (((state == ST_IDLE) && (wait_cfg == 4'd0)) ||
                            ((state == ST_WAITST) && (cnt == 4'd1)));
  assign data_acc  = go_ack && (reg_sel == REG_DATA) && en;
  assign fifo_push = data_acc && we_i && !fifo_full;
  assign fifo_pop  = data_acc && !we_i && !fifo_empty;

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      REG_CTRL: rdata = {6'b0, ctrl};
      REG_DATA: rdata = (en && !fifo_empty) ? fifo_dout : 8'h00;
      REG_STAT: rdata = {4'b0, ovf, unf, fifo_full, fifo_empty};
      REG_WAIT: rdata = {4'b0, wait_cfg};
      default:  rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      ctrl     <= 2'b00;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      wait_cfg <= 4'(RESET_WAIT);
      ack_o    <= 1'b0;
      dat_o    <= 8'h00;
      irq_o    <= 1'b0;
    end else begin
      ack_o <= go_ack;
      dat_o <= 8'h00;
      irq_o <= irq_en && en && ((fifo_count != '0) || ovf || unf);

      case (state)
        ST_IDLE: begin
          if (req) begin
            if (wait_cfg == 4'd0) begin
              state <= ST_ACK;
            end else begin
              state <= ST_WAITST;
              cnt   <= wait_cfg;
            end
          end
        end
        ST_WAITST: begin
          if (!req)             state <= ST_IDLE;
          else if (cnt == 4'd1) state <= ST_ACK;
          else                  cnt   <= cnt - 4'd1;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (go_ack) begin
        if (!we_i) begin
          dat_o <= rdata;
          if ((reg_sel == REG_DATA) && en && fifo_empty) unf <= 1'b1;
        end else begin
          case (reg_sel)
            REG_CTRL: ctrl <= dat_i[1:0];
            REG_DATA: if (en && fifo_full) ovf <= 1'b1;
            REG_STAT: begin
              if (dat_i[STAT_OVF_BIT]) ovf <= 1'b0;
              if (dat_i[STAT_UNF_BIT]) unf <= 1'b0;
            end
            REG_WAIT: wait_cfg <= (dat_i > 8'(MAX_WAIT)) ? 4'(MAX_WAIT) : dat_i[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  wb_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dat_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_slave_responder: directed bench for wb_slave_responder      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_wb_slave_responder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [1:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       irq_o;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_DATA = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_WAIT = 2'd3;

  always #5 clk_i = ~clk_i;

  wb_slave_responder #(
    .FIFO_DEPTH (8),
    .MAX_WAIT   (15),
    .RESET_WAIT (0)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .irq_o (irq_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One classic cycle; lat counts rising edges from the sampling edge to ack.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int lat);
    rd  = 8'h00;
    lat = 0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (ack_o) begin
        lat = n;
        rd  = dat_o;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (lat == 0) chk("ack_timeout", 0, 1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] rd;
    int lat;
    xfer(1'b1, a, d, rd, lat);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    int lat;
    xfer(1'b0, a, a == A_DATA ? 8'h00 : 8'hFF, rd, lat);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    int acks;

    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = 8'h00;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_irq", irq_o, 0);
    rst_i = 1'b1;

    // Reset values and zero-wait latency
    xfer(1'b0, A_CTRL, 8'h00, rd, lat);
    chk("rst_ctrl", rd, 8'h00);
    chk("lat_w0", lat, 1);
    rd_chk("rst_data", A_DATA, 8'h00);
    rd_chk("rst_stat", A_STAT, 8'h01);
    rd_chk("rst_wait", A_WAIT, 8'h00);
    chk("irq_idle", irq_o, 0);

    // Three wait states
    wr(A_WAIT, 8'h03);
    rd_chk("wait_rb", A_WAIT, 8'h03);
    xfer(1'b1, A_CTRL, 8'h03, rd, lat);
    chk("lat_w3", lat, 4);
    rd_chk("ctrl_rb", A_CTRL, 8'h03);

    // Abort: strobe drops in the second wait cycle
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = A_CTRL; dat_i = 8'h00;
    repeat (2) @(negedge clk_i);
    stb_i = 1'b0;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    cyc_i = 1'b0; we_i = 1'b0;
    chk("abort_no_ack", acks, 0);
    rd_chk("abort_ctrl", A_CTRL, 8'h03);
    wr(A_WAIT, 8'h00);

    // Loopback
    wr(A_DATA, 8'hA5);
    wr(A_DATA, 8'h3C);
    @(negedge clk_i);
    chk("irq_data", irq_o, 1);
    rd_chk("pop0", A_DATA, 8'hA5);
    rd_chk("pop1", A_DATA, 8'h3C);
    rd_chk("stat_drained", A_STAT, 8'h01);
    @(negedge clk_i);
    chk("irq_drained", irq_o, 0);

    // EN=0 discards writes
    wr(A_CTRL, 8'h02);
    wr(A_DATA, 8'h55);
    rd_chk("en0_read", A_DATA, 8'h00);
    wr(A_CTRL, 8'h03);
    rd_chk("en0_stat", A_STAT, 8'h01);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) wr(A_DATA, 8'(8'h10 + i));
    rd_chk("stat_full", A_STAT, 8'h02);
    wr(A_DATA, 8'h77);
    rd_chk("stat_ovf", A_STAT, 8'h0A);
    @(negedge clk_i);
    chk("irq_ovf", irq_o, 1);
    for (int i = 0; i < 8; i++) rd_chk("drain", A_DATA, 8'(8'h10 + i));
    wr(A_STAT, 8'h08);
    rd_chk("stat_ovf_clr", A_STAT, 8'h01);

    // Underflow and W1C
    rd_chk("unf_read", A_DATA, 8'h00);
    rd_chk("stat_unf", A_STAT, 8'h05);
    @(negedge clk_i);
    chk("irq_unf", irq_o, 1);
    wr(A_STAT, 8'h0C);
    rd_chk("stat_w1c", A_STAT, 8'h01);
    @(negedge clk_i);
    chk("irq_w1c", irq_o, 0);

    // Reset during wait states
    wr(A_WAIT, 8'h03);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = A_STAT;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("rst_mid_no_ack", acks, 0);
    xfer(1'b0, A_STAT, 8'h00, rd, lat);
    chk("post_rst_stat", rd, 8'h01);
    chk("post_rst_lat", lat, 1);
    rd_chk("post_rst_ctrl", A_CTRL, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
